tx_report_arbiter: RTL and testbench

TX_REPORT_ARBITER -- requirements
Module: tx_report_arbiter

---
 rtl/tx_report_arbiter.sv | 125 ++++++++++++
 tb/tb_tx_report_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_report_arbiter.sv
// Shares one TX FIFO write port between RX echo bytes and decimal counter reports ("dddd\r\n").
// Define RPT_ZERO_BLANK_EN to print leading zero digits as spaces; the units digit is always printed.
module tx_report_arbiter #(
  parameter int unsigned W_CNT   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             echo_valid,
  input  logic [7:0]       echo_data,
  output logic             echo_ready,
  input  logic             rpt_req,
  input  logic [W_CNT-1:0] counter,
  input  logic             tx_full,
  output logic             tx_push,
  output logic [7:0]       tx_wdata,
  output logic             busy
);

  localparam int unsigned SW = $clog2(W_CNT + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(W_CNT - 1);
  localparam logic [W_CNT-1:0] MAX_CNT = W_CNT'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  state_t           state, state_nxt;
  logic             pending;
  logic [W_CNT-1:0] bin;
  logic [15:0]      bcd, bcd_nxt;
  logic [SW-1:0]    step;
  logic [2:0]       idx;
  logic [W_CNT-1:0] clamped;
  logic [3:0]       digit;
  logic             blank;
  logic [7:0]       rpt_byte;
  logic             rpt_push, echo_push;

  assign clamped = (counter > MAX_CNT) ? MAX_CNT : counter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pending) state_nxt = CONV;
      CONV:    if (step == LAST_STEP) state_nxt = SEND;
      SEND:    if (!tx_full && idx == 3'd5) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_nxt = bcd;
    for (int unsigned d = 0; d < 4; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_nxt[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_nxt[14:0], bin[W_CNT-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      bin     <= '0;
      bcd     <= '0;
      step    <= '0;
      idx     <= '0;
    end else begin
      // A request landing on the capture edge wins, so it produces a fresh report.
      if (rpt_req)                     pending <= 1'b1;
      else if (state == IDLE && pending) pending <= 1'b0;
      unique case (state)
        IDLE: if (pending) begin
          bin  <= clamped;
          bcd  <= '0;
          step <= '0;
        end
        CONV: begin
          bcd  <= bcd_nxt;
          bin  <= {bin[W_CNT-2:0], 1'b0};
          step <= step + 1'b1;
        end
        SEND: if (!tx_full) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (idx)
      3'd0:    digit = bcd[15:12];
      3'd1:    digit = bcd[11:8];
      3'd2:    digit = bcd[7:4];
      default: digit = bcd[3:0];
    endcase
`ifdef RPT_ZERO_BLANK_EN
    unique case (idx)
      3'd0:    blank = (bcd[15:12] == 4'd0);
      3'd1:    blank = (bcd[15:8] == 8'd0);
      3'd2:    blank = (bcd[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (idx < 3'd4)       rpt_byte = blank ? 8'h20 : {4'h3, digit};
    else if (idx == 3'd4) rpt_byte = 8'h0D;
    else                  rpt_byte = 8'h0A;
  end

  always_comb begin
    echo_ready = (state != SEND) && !tx_full;
    rpt_push   = (state == SEND) && !tx_full;
    echo_push  = echo_valid && echo_ready;
    tx_push    = rpt_push || echo_push;
    if (rpt_push)       tx_wdata = rpt_byte;
    else if (echo_push) tx_wdata = echo_data;
    else                tx_wdata = '0;
    busy = (state != IDLE) || pending;
  end

endmodule

// File: tb/tb_tx_report_arbiter.sv
// Bench for tx_report_arbiter: report vectors, FIFO stall, echo blocking/coalescing and mid-report reset.
// Expected bytes follow RPT_ZERO_BLANK_EN when it is defined for the build.
module tb_tx_report_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        echo_valid = 1'b0;
  logic [7:0]  echo_data = '0;
  logic        echo_ready;
  logic        rpt_req = 1'b0;
  logic [13:0] counter = '0;
  logic        tx_full = 1'b0;
  logic        tx_push;
  logic [7:0]  tx_wdata;
  logic        busy;

  tx_report_arbiter #(.W_CNT(14), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .echo_valid(echo_valid), .echo_data(echo_data),
    .echo_ready(echo_ready), .rpt_req(rpt_req), .counter(counter), .tx_full(tx_full),
    .tx_push(tx_push), .tx_wdata(tx_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] cnt;
    logic [47:0] bytes_exp;
  } vec_t;
  vec_t vecs[7];
  logic [47:0] r42;

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  logic [7:0] exp_q[$];
  int push_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every committed-looking push must match the oldest expected byte.
  always @(negedge clk) begin
    if (tx_push) begin
      n_push++;
      push_cyc_q.push_back(cyc);
      check("push_while_full", tx_full, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push actual=%0h expected=none", tx_wdata);
      end else begin
        check("tx_wdata", tx_wdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [47:0] b);
    for (int i = 0; i < 6; i++) exp_q.push_back(b[47-8*i -: 8]);
  endtask

  task automatic start_report(input logic [13:0] val, input logic [47:0] b, output int cyc_p);
    counter = val;
    tick();
    rpt_req = 1'b1;
    tick();
    cyc_p = cyc;
    rpt_req = 1'b0;
    push_exp(b);
    check("busy_pending", busy, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_pushes(input int target, input int bound);
    int n = 0;
    while (n_push < target && n < bound) begin
      tick();
      n++;
    end
    check("push_wait", n_push >= target, 1'b1);
  endtask

  task automatic run_vector(input logic [13:0] val, input logic [47:0] b);
    int cyc_p;
    push_cyc_q.delete();
    start_report(val, b, cyc_p);
    wait_drain("report_drain", 60);
    check("push_count", push_cyc_q.size(), 6);
    if (push_cyc_q.size() >= 6) begin
      check("first_latency", push_cyc_q[0] - cyc_p, 15);
      check("burst_span", push_cyc_q[5] - push_cyc_q[0], 5);
    end
    tick();
    tick();
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int n0, cyc_p;
    logic accepted;

    vecs[0] = '{14'd1234,  {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}};
    vecs[2] = '{14'd16383, {8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A}};
    vecs[4] = '{14'd10000, {8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A}};
    vecs[6] = '{14'd9999,  {8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A}};
`ifdef RPT_ZERO_BLANK_EN
    vecs[1] = '{14'd7,   {8'h20, 8'h20, 8'h20, 8'h37, 8'h0D, 8'h0A}};
    vecs[3] = '{14'd0,   {8'h20, 8'h20, 8'h20, 8'h30, 8'h0D, 8'h0A}};
    vecs[5] = '{14'd605, {8'h20, 8'h36, 8'h30, 8'h35, 8'h0D, 8'h0A}};
    r42 = {8'h20, 8'h20, 8'h34, 8'h32, 8'h0D, 8'h0A};
`else
    vecs[1] = '{14'd7,   {8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A}};
    vecs[3] = '{14'd0,   {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
    vecs[5] = '{14'd605, {8'h30, 8'h36, 8'h30, 8'h35, 8'h0D, 8'h0A}};
    r42 = {8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
`endif

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("reset_tx_push", tx_push, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wdata", tx_wdata, 8'h00);
    check("reset_echo_ready", echo_ready, 1'b1);
    tx_full = 1'b1;
    #1 check("reset_echo_ready_full", echo_ready, 1'b0);
    tx_full = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Plain echo in IDLE, then blocked by a full FIFO
    exp_q.push_back(8'h5A);
    echo_data = 8'h5A;
    echo_valid = 1'b1;
    tick();
    check("echo_idle_ready", echo_ready, 1'b1);
    check("echo_idle_push", tx_push, 1'b1);
    tx_full = 1'b1;
    tick();
    check("echo_full_ready", echo_ready, 1'b0);
    check("echo_full_push", tx_push, 1'b0);
    echo_valid = 1'b0;
    tx_full = 1'b0;
    wait_drain("echo_drain", 2);

    for (int v = 0; v < 7; v++) run_vector(vecs[v].cnt, vecs[v].bytes_exp);

    // Five-cycle FIFO stall after the second report byte
    push_cyc_q.delete();
    n0 = n_push;
    start_report(14'd1234, vecs[0].bytes_exp, cyc_p);
    wait_pushes(n0 + 2, 40);
    @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (5) tick();
    check("stall_no_push", n_push - n0, 2);
    @(posedge clk);
    #1 tx_full = 1'b0;
    wait_drain("stall_drain", 40);
    check("stall_push_count", push_cyc_q.size(), 6);
    if (push_cyc_q.size() >= 6) begin
      check("stall_gap", push_cyc_q[2] - push_cyc_q[1], 6);
      check("stall_tail", push_cyc_q[5] - push_cyc_q[2], 3);
    end

    // Echo held off during SEND; three requests coalesce into one report
    push_cyc_q.delete();
    n0 = n_push;
    start_report(14'd1234, vecs[0].bytes_exp, cyc_p);
    exp_q.push_back(8'h41);
    push_exp(r42);
    wait_pushes(n0 + 1, 40);
    echo_data = 8'h41;
    echo_valid = 1'b1;
    #1 check("echo_blocked_send", echo_ready, 1'b0);
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rpt_req = (i == 1 || i == 3 || i == 5);
      if (i == 2) counter = 14'd42;
      tick();
      if (echo_ready) begin
        check("echo_after_report", n_push - n0, 7);
        accepted = 1'b1;
        break;
      end
    end
    rpt_req = 1'b0;
    check("echo_accepted", accepted, 1'b1);
    @(posedge clk);
    #1 echo_valid = 1'b0;
    wait_drain("coalesce_drain", 60);
    repeat (30) tick();
    check("coalesced_pushes", n_push - n0, 13);
    if (push_cyc_q.size() >= 13) check("echo_then_conv_latency", push_cyc_q[7] - push_cyc_q[6], 15);
    check("coalesce_busy", busy, 1'b0);

    // Reset in the middle of SEND after the third byte
    n0 = n_push;
    start_report(14'd1234, vecs[0].bytes_exp, cyc_p);
    wait_pushes(n0 + 3, 40);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_tx_push", tx_push, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_wdata", tx_wdata, 8'h00);
    check("midrst_echo_ready", echo_ready, 1'b1);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("midrst_no_resume", n_push - n0, 3);
    check("midrst_busy_after", busy, 1'b0);

    run_vector(vecs[5].cnt, vecs[5].bytes_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
